// File: rtl/match_event_logger.sv
// match_event_logger
//   Timestamps every match reported by the serial sequence detector. It keeps a
//   saturating match count and the gap between the two most recent matches, and
//   buffers match timestamps in a first-word fall-through FIFO. A host drains the
//   FIFO over a valid/ready handshake. It runs on the detector's bit clock, so
//   one cycle equals one serial bit.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   en           enables timestamping and event capture (FIFO readout unaffected)
//   clear        synchronous soft clear; same effect as rst, wins over events/pops
//   match_in     detector match flag, sampled every cycle
//   ts_valid     FIFO non-empty
//   ts_data      head timestamp (0 while ts_valid=0)
//   ts_ready     consumer accepts the head entry
//   match_count  saturating count of accepted matches
//   last_gap     cycles between the two most recent matches, saturating
//   fifo_level   occupied FIFO entries
//   overflow     sticky: a match was dropped because the FIFO was full
module match_event_logger #(
    parameter int TS_W  = 16,
    parameter int CNT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     match_in,
    output logic                     ts_valid,
    output logic [TS_W-1:0]          ts_data,
    input  logic                     ts_ready,
    output logic [CNT_W-1:0]         match_count,
    output logic [TS_W-1:0]          last_gap,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  gap_q, gap_d;
    logic             has_prev_q, has_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TS_W-1:0]  last_gap_q, last_gap_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [TS_W-1:0]  mem [DEPTH];

    logic evt;
    logic empty;
    logic full;
    logic pop;
    logic push;

    always_comb begin
        evt   = en & match_in;
        empty = (level_q == '0);
        full  = (level_q == LW'(DEPTH));
        pop   = ~empty & ts_ready;
        // A full FIFO can still take a push when the head leaves in the same cycle.
        push  = evt & (~full | pop);

        ts_d       = ts_q;
        gap_d      = gap_q;
        has_prev_d = has_prev_q;
        cnt_d      = cnt_q;
        last_gap_d = last_gap_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;

        if (en) begin
            ts_d = ts_q + TS_W'(1);
        end

        if (evt) begin
            gap_d      = '0;
            has_prev_d = 1'b1;
            // gap_ctr counts idle en-cycles; the gap between events is one more.
            if (has_prev_q) begin
                last_gap_d = (gap_q == '1) ? '1 : gap_q + TS_W'(1);
            end else begin
                last_gap_d = '0;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!push) begin
                ovf_d = 1'b1;
            end
        end else if (en) begin
            if (gap_q != '1) begin
                gap_d = gap_q + TS_W'(1);
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ts_q       <= '0;
            gap_q      <= '0;
            has_prev_q <= 1'b0;
            cnt_q      <= '0;
            last_gap_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            gap_q      <= gap_d;
            has_prev_q <= has_prev_d;
            cnt_q      <= cnt_d;
            last_gap_q <= last_gap_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible through level/pointers,
    // which are reset, and ts_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= ts_q;
        end
    end

    assign ts_valid    = ~empty;
    assign ts_data     = ts_valid ? mem[rd_ptr_q] : '0;
    assign match_count = cnt_q;
    assign last_gap    = last_gap_q;
    assign fifo_level  = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_match_event_logger.sv
// tb_match_event_logger
//   Directed scenarios on a default-size logger (TS_W=16, CNT_W=16, DEPTH=8) and
//   a wrap scenario plus randomized traffic on a small logger (TS_W=4, CNT_W=3,
//   DEPTH=4). The random traffic is compared against a model that tracks an
//   unbounded enabled-cycle count, a timestamp queue and the event history.
module tb_match_event_logger;

    localparam int S_TS_W  = 4;
    localparam int S_CNT_W = 3;
    localparam int S_DEPTH = 4;
    localparam int S_TSMOD = 1 << S_TS_W;
    localparam int S_CNTMX = (1 << S_CNT_W) - 1;
    localparam int S_GAPMX = S_TSMOD - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic match_in = 1'b0;
    logic ts_ready = 1'b0;

    logic        b_ts_valid;
    logic [15:0] b_ts_data;
    logic [15:0] b_match_count;
    logic [15:0] b_last_gap;
    logic [3:0]  b_fifo_level;
    logic        b_overflow;

    logic        s_ts_valid;
    logic [3:0]  s_ts_data;
    logic [2:0]  s_match_count;
    logic [3:0]  s_last_gap;
    logic [2:0]  s_fifo_level;
    logic        s_overflow;

    int errors = 0;
    int checks = 0;

    // reference model state (small DUT)
    longint m_ecyc;
    longint m_last_ev;
    bit     m_has_prev;
    int     m_cnt;
    int     m_gap;
    bit     m_ovf;
    int     m_q[$];

    match_event_logger #(.TS_W(16), .CNT_W(16), .DEPTH(8)) u_big (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .match_in(match_in),
        .ts_valid(b_ts_valid), .ts_data(b_ts_data), .ts_ready(ts_ready),
        .match_count(b_match_count), .last_gap(b_last_gap),
        .fifo_level(b_fifo_level), .overflow(b_overflow)
    );

    match_event_logger #(.TS_W(S_TS_W), .CNT_W(S_CNT_W), .DEPTH(S_DEPTH)) u_small (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .match_in(match_in),
        .ts_valid(s_ts_valid), .ts_data(s_ts_data), .ts_ready(ts_ready),
        .match_count(s_match_count), .last_gap(s_last_gap),
        .fifo_level(s_fifo_level), .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; en = 1'b0; match_in = 1'b0; ts_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic model_step();
        bit ev;
        bit pop;
        int sz;
        longint g;
        if (rst || clear) begin
            m_ecyc = 0; m_last_ev = 0; m_has_prev = 0;
            m_cnt = 0; m_gap = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            ev  = en && match_in;
            sz  = m_q.size();
            pop = (sz > 0) && ts_ready;
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (sz < S_DEPTH || pop) m_q.push_back(int'(m_ecyc % S_TSMOD));
                else m_ovf = 1;
                if (m_cnt < S_CNTMX) m_cnt++;
                g = m_ecyc - m_last_ev;
                m_gap = m_has_prev ? ((g > S_GAPMX) ? S_GAPMX : int'(g)) : 0;
                m_last_ev = m_ecyc;
                m_has_prev = 1;
            end
            if (en) m_ecyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        cyc();
        checks++; if (b_ts_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", b_ts_valid); end
        checks++; if (b_ts_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", b_ts_data); end
        checks++; if (b_match_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", b_match_count); end
        checks++; if (b_last_gap !== 16'd0) begin errors++; $display("FAIL reset_gap: got %0d expected 0", b_last_gap); end
        checks++; if (b_fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", b_fifo_level); end
        checks++; if (b_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", b_overflow); end
        checks++; if (s_fifo_level !== 3'd0 || s_ts_valid !== 1'b0) begin errors++; $display("FAIL reset_small: level %0d valid %0d expected 0 0", s_fifo_level, s_ts_valid); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            match_in = (k == 3 || k == 7 || k == 8);
            cyc();
        end
        match_in = 1'b0; en = 1'b0;
        checks++; if (b_match_count !== 16'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", b_match_count); end
        checks++; if (b_last_gap !== 16'd1) begin errors++; $display("FAIL basic_gap: got %0d expected 1", b_last_gap); end
        checks++; if (b_fifo_level !== 4'd3) begin errors++; $display("FAIL basic_level: got %0d expected 3", b_fifo_level); end
        checks++; if (b_ts_valid !== 1'b1 || b_ts_data !== 16'd3) begin errors++; $display("FAIL basic_head: valid %0d data %0d expected 1 3", b_ts_valid, b_ts_data); end
        ts_ready = 1'b1;
        cyc();
        checks++; if (b_ts_data !== 16'd7) begin errors++; $display("FAIL basic_pop1: got %0d expected 7", b_ts_data); end
        cyc();
        checks++; if (b_ts_data !== 16'd8) begin errors++; $display("FAIL basic_pop2: got %0d expected 8", b_ts_data); end
        cyc();
        checks++; if (b_ts_valid !== 1'b0 || b_ts_data !== 16'd0) begin errors++; $display("FAIL basic_empty: valid %0d data %0d expected 0 0", b_ts_valid, b_ts_data); end
        ts_ready = 1'b0;
    endtask

    task automatic test_stream();
        bit ev_k;
        do_reset();
        en = 1'b1; ts_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            ev_k = (k == 3 || k == 7 || k == 8);
            match_in = ev_k;
            cyc();
            checks++;
            if (b_ts_valid !== ev_k || b_ts_data !== (ev_k ? 16'(k) : 16'd0)) begin
                errors++;
                $display("FAIL stream_k%0d: valid %0d data %0d expected %0d %0d", k, b_ts_valid, b_ts_data, ev_k, ev_k ? k : 0);
            end
        end
        match_in = 1'b0; ts_ready = 1'b0; en = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        en = 1'b1; match_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 7) begin
                checks++; if (b_fifo_level !== 4'd8 || b_overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full: level %0d ovf %0d expected 8 0", b_fifo_level, b_overflow); end
            end
        end
        match_in = 1'b0; en = 1'b0;
        checks++; if (b_fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", b_fifo_level); end
        checks++; if (b_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0d expected 1", b_overflow); end
        checks++; if (b_match_count !== 16'd10) begin errors++; $display("FAIL ovf_count: got %0d expected 10", b_match_count); end
        ts_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (b_ts_valid !== 1'b1 || b_ts_data !== 16'(k)) begin errors++; $display("FAIL ovf_drain%0d: valid %0d data %0d expected 1 %0d", k, b_ts_valid, b_ts_data, k); end
            cyc();
        end
        checks++; if (b_ts_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", b_ts_valid); end
        ts_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        en = 1'b1; match_in = 1'b1;
        for (int k = 0; k < 8; k++) cyc();
        ts_ready = 1'b1;
        cyc();
        match_in = 1'b0; en = 1'b0;
        checks++; if (b_fifo_level !== 4'd8 || b_overflow !== 1'b0) begin errors++; $display("FAIL fullpop_level: level %0d ovf %0d expected 8 0", b_fifo_level, b_overflow); end
        for (int k = 1; k < 9; k++) begin
            checks++; if (b_ts_data !== 16'(k)) begin errors++; $display("FAIL fullpop_drain%0d: got %0d expected %0d", k, b_ts_data, k); end
            cyc();
        end
        ts_ready = 1'b0;
    endtask

    task automatic test_en_gate();
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 10; k++) cyc();
        match_in = 1'b1; cyc();
        en = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        en = 1'b1; cyc();
        match_in = 1'b0; en = 1'b0;
        checks++; if (b_match_count !== 16'd2) begin errors++; $display("FAIL engate_count: got %0d expected 2", b_match_count); end
        checks++; if (b_last_gap !== 16'd1) begin errors++; $display("FAIL engate_gap: got %0d expected 1", b_last_gap); end
        checks++; if (b_fifo_level !== 4'd2 || b_ts_data !== 16'd10) begin errors++; $display("FAIL engate_head: level %0d data %0d expected 2 10", b_fifo_level, b_ts_data); end
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;
        checks++; if (b_ts_data !== 16'd11) begin errors++; $display("FAIL engate_second: got %0d expected 11", b_ts_data); end
    endtask

    task automatic test_clear();
        do_reset();
        en = 1'b1; match_in = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        clear = 1'b1; ts_ready = 1'b1;
        cyc();
        clear = 1'b0; ts_ready = 1'b0;
        checks++; if (b_ts_valid !== 1'b0 || b_ts_data !== 16'd0 || b_fifo_level !== 4'd0) begin errors++; $display("FAIL clear_fifo: valid %0d data %0d level %0d expected 0 0 0", b_ts_valid, b_ts_data, b_fifo_level); end
        checks++; if (b_match_count !== 16'd0 || b_last_gap !== 16'd0 || b_overflow !== 1'b0) begin errors++; $display("FAIL clear_stats: count %0d gap %0d ovf %0d expected 0 0 0", b_match_count, b_last_gap, b_overflow); end
        cyc();
        match_in = 1'b0; en = 1'b0;
        checks++; if (b_ts_data !== 16'd0 || b_match_count !== 16'd1 || b_last_gap !== 16'd0) begin errors++; $display("FAIL clear_after: data %0d count %0d gap %0d expected 0 1 0", b_ts_data, b_match_count, b_last_gap); end
    endtask

    task automatic test_wrap();
        do_reset();
        en = 1'b1; match_in = 1'b1; cyc();
        match_in = 1'b0;
        for (int k = 0; k < S_TSMOD + 5; k++) cyc();
        match_in = 1'b1; cyc();
        match_in = 1'b0; en = 1'b0;
        checks++; if (s_last_gap !== 4'd15) begin errors++; $display("FAIL wrap_gap: got %0d expected 15", s_last_gap); end
        checks++; if (s_fifo_level !== 3'd2 || s_match_count !== 3'd2) begin errors++; $display("FAIL wrap_level: level %0d count %0d expected 2 2", s_fifo_level, s_match_count); end
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;
        checks++; if (s_ts_data !== 4'd6) begin errors++; $display("FAIL wrap_ts: got %0d expected 6", s_ts_data); end
    endtask

    task automatic test_random();
        int exp_data;
        rst = 1'b1; clear = 1'b0; en = 1'b0; match_in = 1'b0; ts_ready = 1'b0;
        @(posedge clk); model_step(); #1;
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            clear    = ($urandom_range(0, 79) == 0);
            en       = ($urandom_range(0, 99) < 80);
            match_in = ($urandom_range(0, 99) < 50);
            ts_ready = ($urandom_range(0, 99) < 40);
            @(posedge clk);
            model_step();
            #1;
            exp_data = (m_q.size() > 0) ? m_q[0] : 0;
            checks++;
            if (s_ts_valid !== (m_q.size() > 0) || s_ts_data !== 4'(exp_data) || s_fifo_level !== 3'(m_q.size())) begin
                errors++;
                $display("FAIL rand_fifo%0d: valid %0d data %0d level %0d expected %0d %0d %0d", i, s_ts_valid, s_ts_data, s_fifo_level, m_q.size() > 0, exp_data, m_q.size());
            end
            checks++;
            if (s_match_count !== 3'(m_cnt) || s_last_gap !== 4'(m_gap) || s_overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_stats%0d: count %0d gap %0d ovf %0d expected %0d %0d %0d", i, s_match_count, s_last_gap, s_overflow, m_cnt, m_gap, m_ovf);
            end
        end
        rst = 1'b0; clear = 1'b0; en = 1'b0; match_in = 1'b0; ts_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_overflow();
        test_full_pop();
        test_en_gate();
        test_clear();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the programmable serial sequence detector's match output (detector `uo_out[0]`). It timestamps every match, keeps a saturating match count and the gap between the last two matches, and buffers timestamps in a small FIFO that host logic drains over a valid/ready interface. It runs on the detector's bit clock, so one cycle equals one serial bit.

## Interface
Parameters:
- `TS_W`, 16: timestamp and gap width (bits).
- `CNT_W`, 16: match counter width.
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  enables timestamping and event capture; FIFO readout is unaffected.
- `clear`  in  1  synchronous soft clear of counters, FIFO and flags.
- `match_in`  in  1  detector match flag, sampled each cycle.
- `ts_valid`  out  1  FIFO non-empty; head entry is on `ts_data`.
- `ts_data`  out  TS_W  timestamp of the oldest buffered match.
- `ts_ready`  in  1  consumer accepts the head entry.
- `match_count`  out  CNT_W  total accepted matches, saturating.
- `last_gap`  out  TS_W  cycles between the two most recent matches, saturating.
- `fifo_level`  out  clog2(DEPTH)+1  number of occupied entries.
- `overflow`  out  1  sticky: a match was dropped because the FIFO was full.

## Operation
- Timestamp counter `ts`, TS_W bits:
  - Increments by 1 each cycle with `en`=1 and wraps modulo 2^TS_W.
  - Holds its value when `en`=0.
- Event: a rising edge with `en`=1 and `match_in`=1. Every such cycle is a distinct event, so consecutive high cycles produce consecutive events (overlapping matches).
- On each event:
  - Push the current `ts` (the value before this edge's increment) into the FIFO.
  - `match_count` increments, holding at 2^CNT_W-1.
  - Gap tracking updates as described below.
- Gap tracking:
  - Internal `gap_ctr` increments on every `en` cycle without an event, saturating at 2^TS_W-1.
  - On an event, `gap_ctr` returns to 0.
  - On an event, `last_gap` loads `gap_ctr`+1 (saturating) if a previous event exists since reset/clear, otherwise 0.
  - The first event sets an internal `has_prev` flag.
- FIFO behaviour:
  - First-word fall-through, DEPTH entries.
  - Pop occurs when `ts_valid` and `ts_ready` are both 1.
  - Full with a simultaneous pop: the push is accepted and the level is unchanged.
  - Full without a pop: the event's timestamp is dropped and `overflow` is set. The count and gap still update.
  - Empty with a push: no pop is possible, because `ts_valid`=0.
  - `ts_data` is forced to 0 whenever `ts_valid`=0.
- `clear`=1:
  - Behaves as `rst` for every state element.
  - Takes priority over an event or pop in the same cycle; that event is discarded.
- `rst` and `clear` mid-operation discard all buffered entries immediately. There is no partial drain.

## Timing
- Reset and clear values:
  - `ts`, `gap_ctr`, `has_prev` = 0.
  - `ts_valid` = 0, `ts_data` = 0.
  - `match_count` = 0, `last_gap` = 0.
  - `fifo_level` = 0, `overflow` = 0.
- All outputs are registered or decoded from registers. There are no combinational paths from inputs to outputs.
- Event at edge N:
  - `match_count`, `last_gap`, `fifo_level` and `overflow` reflect it after edge N.
  - On an empty FIFO, `ts_valid`=1 with the new `ts_data` after edge N.
- Pop at edge N: the next entry, or `ts_valid`=0, is presented after edge N.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset, `en`=1, `match_in` pulses at cycles 3, 7 and 8 (counting from `ts`=0) -> FIFO holds 3, 7, 8; `match_count`=3; `last_gap`=1; `fifo_level`=3.
- `ts_ready` held at 1 during the first scenario -> each timestamp appears for exactly one cycle after its push, in order 3, 7, 8; `ts_valid` returns to 0.
- `match_in` held high for DEPTH+2 cycles with `ts_ready`=0 -> `fifo_level`=DEPTH, `overflow`=1, `match_count`=DEPTH+2, FIFO holds the first DEPTH timestamps.
- Full FIFO with `ts_ready`=1 and a simultaneous event -> level stays DEPTH, `overflow` stays 0, the newest timestamp is appended at the tail.
- `en`=0 for 5 cycles between matches at `ts` 10 and 11 -> timestamps 10 and 11 (`ts` frozen); `last_gap`=1; events with `en`=0 are ignored.
- `clear` asserted in the same cycle as an event with 3 entries buffered -> next cycle all outputs are 0 and the event is not recorded.
- Run 2^TS_W+5 idle cycles, then a match (`TS_W` may be reduced to 4 for this scenario):
  - Timestamp equals the wrapped `ts`.
  - `last_gap` saturates at 2^TS_W-1.
